// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and the rest of the controller:
// decoder feedback, memory wait, interrupt gates, one-hot phase strobes and status.
interface instr_sequencer_if #(
    parameter int CW = 8
);
    // Inputs to the sequencer
    logic          MEM_WAIT;
    logic          SRC_MEM;
    logic          DST_MEM;
    logic          EX_WB;
    logic          op_MUL;
    logic          op_SVC;
    logic          EIT_gate;
    logic          OIT_gate;
    logic          STEP;

    // One-hot phase strobes
    logic          IF0;
    logic          IF1;
    logic          FF0;
    logic          FF1;
    logic          FF2;
    logic          TF0;
    logic          TF1;
    logic          EX0;
    logic          EX1;
    logic          IT0;
    logic          IT1;
    logic          IT2;
    logic          MUL1;
    logic          MUL2_1;
    logic          MUL2_2;
    logic          MUL3;
    logic          MUL4;

    // Status
    logic [CW-1:0] mul_cnt;
    logic          instr_done;

    modport master (
        output MEM_WAIT, SRC_MEM, DST_MEM, EX_WB, op_MUL, op_SVC,
               EIT_gate, OIT_gate, STEP,
        input  IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1,
               IT0, IT1, IT2, MUL1, MUL2_1, MUL2_2, MUL3, MUL4,
               mul_cnt, instr_done
    );

    modport slave (
        input  MEM_WAIT, SRC_MEM, DST_MEM, EX_WB, op_MUL, op_SVC,
               EIT_gate, OIT_gate, STEP,
        output IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1,
               IT0, IT1, IT2, MUL1, MUL2_1, MUL2_2, MUL3, MUL4,
               mul_cnt, instr_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction phase sequencer: fetch, operand fetch, execute, multiply loop and
// interrupt entry. Define SEQ_SINGLE_STEP_EN to gate every instruction on a STEP edge.
module instr_sequencer #(
    parameter int MUL_ITER = 16,
    parameter int CW       = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    instr_sequencer_if.slave bus
);

    typedef enum logic [4:0] {
        S_IF0    = 5'd0,
        S_IF1    = 5'd1,
        S_FF0    = 5'd2,
        S_FF1    = 5'd3,
        S_FF2    = 5'd4,
        S_TF0    = 5'd5,
        S_TF1    = 5'd6,
        S_EX0    = 5'd7,
        S_EX1    = 5'd8,
        S_IT0    = 5'd9,
        S_IT1    = 5'd10,
        S_IT2    = 5'd11,
        S_MUL1   = 5'd12,
        S_MUL2_1 = 5'd13,
        S_MUL2_2 = 5'd14,
        S_MUL3   = 5'd15,
        S_MUL4   = 5'd16
    } state_t;

    localparam int NSTATES = 17;

    state_t               state;
    state_t               next_state;
    logic [NSTATES-1:0]   strobe_q;
    logic [CW-1:0]        cnt_q;
    logic                 end_of_instr;
    logic                 done_c;
    logic                 irq;
    logic                 mul_last;
    logic                 if0_go;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_hold;
    logic step_rise;

    assign step_rise = bus.STEP & ~step_q;
    assign if0_go    = ~step_hold;

    // Hold is armed on every entry into IF0 and released by a STEP rising edge seen in IF0.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            step_q    <= 1'b0;
            step_hold <= 1'b1;
        end else begin
            step_q <= bus.STEP;
            if (next_state == S_IF0 && state != S_IF0)
                step_hold <= 1'b1;
            else if (state == S_IF0 && step_hold && step_rise)
                step_hold <= 1'b0;
        end
    end
`else
    logic unused_step;

    assign unused_step = bus.STEP;
    assign if0_go      = 1'b1;
`endif

    assign irq      = bus.EIT_gate | bus.OIT_gate;
    assign mul_last = (cnt_q == CW'(MUL_ITER - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state   = S_IF0;
        end_of_instr = 1'b0;
        done_c       = 1'b0;

        case (state)
            S_IF0:    next_state = (if0_go && !bus.MEM_WAIT) ? S_IF1 : S_IF0;
            S_IF1: begin
                if (bus.op_SVC)       next_state = S_IT0;
                else if (bus.op_MUL)  next_state = S_MUL1;
                else if (bus.SRC_MEM) next_state = S_FF0;
                else if (bus.DST_MEM) next_state = S_TF0;
                else                  next_state = S_EX0;
            end
            S_FF0:    next_state = S_FF1;
            S_FF1:    next_state = bus.MEM_WAIT ? S_FF1 : S_FF2;
            S_FF2:    next_state = bus.DST_MEM ? S_TF0 : S_EX0;
            S_TF0:    next_state = S_TF1;
            S_TF1:    next_state = bus.MEM_WAIT ? S_TF1 : S_EX0;
            S_EX0: begin
                if (bus.EX_WB) next_state   = S_EX1;
                else           end_of_instr = 1'b1;
            end
            S_EX1: begin
                if (bus.MEM_WAIT) next_state   = S_EX1;
                else              end_of_instr = 1'b1;
            end
            S_IT0:    next_state = S_IT1;
            S_IT1:    next_state = bus.MEM_WAIT ? S_IT1 : S_IT2;
            S_IT2: begin
                // Interrupt entry completes unconditionally; pending requests wait for the next instruction.
                next_state = S_IF0;
                done_c     = 1'b1;
            end
            S_MUL1:   next_state = S_MUL2_1;
            S_MUL2_1: next_state = S_MUL2_2;
            S_MUL2_2: next_state = mul_last ? S_MUL3 : S_MUL2_1;
            S_MUL3:   next_state = S_MUL4;
            S_MUL4:   end_of_instr = 1'b1;
            default:  next_state = S_IF0;
        endcase

        if (end_of_instr) begin
            done_c     = 1'b1;
            next_state = irq ? S_IT0 : S_IF0;
        end
    end

    // Strobes are registered from the decoded next state, so they are glitch-free and always one-hot.
    always_ff @(posedge CLK or negedge CLR) begin
        // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
        if (!CLR) begin
            state    <= S_IF0;
            strobe_q <= NSTATES'(1);
            cnt_q    <= '0;
        end else begin
            state    <= next_state;
            strobe_q <= NSTATES'(1) << next_state;
            if (state == S_MUL1)
                cnt_q <= '0;
            else if (state == S_MUL2_2 && !mul_last)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.IF0        = strobe_q[S_IF0];
    assign bus.IF1        = strobe_q[S_IF1];
    assign bus.FF0        = strobe_q[S_FF0];
    assign bus.FF1        = strobe_q[S_FF1];
    assign bus.FF2        = strobe_q[S_FF2];
    assign bus.TF0        = strobe_q[S_TF0];
    assign bus.TF1        = strobe_q[S_TF1];
    assign bus.EX0        = strobe_q[S_EX0];
    assign bus.EX1        = strobe_q[S_EX1];
    assign bus.IT0        = strobe_q[S_IT0];
    assign bus.IT1        = strobe_q[S_IT1];
    assign bus.IT2        = strobe_q[S_IT2];
    assign bus.MUL1       = strobe_q[S_MUL1];
    assign bus.MUL2_1     = strobe_q[S_MUL2_1];
    assign bus.MUL2_2     = strobe_q[S_MUL2_2];
    assign bus.MUL3       = strobe_q[S_MUL3];
    assign bus.MUL4       = strobe_q[S_MUL4];
    assign bus.mul_cnt    = cnt_q;
    assign bus.instr_done = done_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: phase sequences, multiply loop, interrupt
// entry, SVC priority and asynchronous reset, with hand-written expected phases.
module tb_instr_sequencer;

    localparam int CW       = 8;
    localparam int MUL_ITER = 16;

    localparam int P_IF0    = 0;
    localparam int P_IF1    = 1;
    localparam int P_FF0    = 2;
    localparam int P_FF1    = 3;
    localparam int P_FF2    = 4;
    localparam int P_TF0    = 5;
    localparam int P_TF1    = 6;
    localparam int P_EX0    = 7;
    localparam int P_EX1    = 8;
    localparam int P_IT0    = 9;
    localparam int P_IT1    = 10;
    localparam int P_IT2    = 11;
    localparam int P_MUL1   = 12;
    localparam int P_MUL2_1 = 13;
    localparam int P_MUL2_2 = 14;
    localparam int P_MUL3   = 15;
    localparam int P_MUL4   = 16;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    int errors = 0;
    int checks = 0;

    instr_sequencer_if #(.CW(CW)) bus ();

    instr_sequencer #(.MUL_ITER(MUL_ITER), .CW(CW)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] strobes();
        return {bus.MUL4, bus.MUL3, bus.MUL2_2, bus.MUL2_1, bus.MUL1,
                bus.IT2, bus.IT1, bus.IT0, bus.EX1, bus.EX0,
                bus.TF1, bus.TF0, bus.FF2, bus.FF1, bus.FF0, bus.IF1, bus.IF0};
    endfunction

    // Expected phase of cycle c of a multiply instruction starting at IF0.
    function automatic int mul_phase(int c);
        if (c == 0)                   return P_IF0;
        if (c == 1)                   return P_IF1;
        if (c == 2)                   return P_MUL1;
        if (c < 3 + 2 * MUL_ITER)     return ((c - 3) % 2 == 0) ? P_MUL2_1 : P_MUL2_2;
        if (c == 3 + 2 * MUL_ITER)    return P_MUL3;
        if (c == 4 + 2 * MUL_ITER)    return P_MUL4;
        return P_IF0;
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_decode(input logic src, input logic dst, input logic wb,
                              input logic mul, input logic svc);
        bus.SRC_MEM = src;
        bus.DST_MEM = dst;
        bus.EX_WB   = wb;
        bus.op_MUL  = mul;
        bus.op_SVC  = svc;
    endtask

    task automatic test_reset();
        bus.MEM_WAIT = 1'b0;
        bus.EIT_gate = 1'b0;
        bus.OIT_gate = 1'b0;
        bus.STEP     = 1'b0;
        set_decode(0, 0, 0, 0, 0);
        #1 CLR = 1'b0;
        #2;
        checks++;
        if (strobes() !== 17'h00001) begin
            errors++;
            $display("FAIL reset_strobes: got %h expected %h", strobes(), 17'h00001);
        end
        checks++;
        if (bus.mul_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mul_cnt: got %0d expected 0", bus.mul_cnt);
        end
        checks++;
        if (bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_instr_done: got %b expected 0", bus.instr_done);
        end
        #5 CLR = 1'b1;
    endtask

    task automatic test_register_op();
        int s [4] = '{P_IF0, P_IF1, P_EX0, P_IF0};
        bit d [4] = '{0, 0, 1, 0};
        set_decode(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.MEM_WAIT = 1'b0;
            #1;
            checks++;
            if (strobes() !== (17'd1 << s[i])) begin
                errors++;
                $display("FAIL reg_op_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s[i]);
            end
            checks++;
            if (bus.instr_done !== d[i]) begin
                errors++;
                $display("FAIL reg_op_done[%0d]: got %b expected %b", i, bus.instr_done, d[i]);
            end
            if (i < 3) next_cycle();
        end
    endtask

    task automatic test_mem_operands();
        int s [13] = '{P_IF0, P_IF1, P_FF0, P_FF1, P_FF1, P_FF1, P_FF1,
                       P_FF2, P_TF0, P_TF1, P_EX0, P_EX1, P_IF0};
        bit w [13] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit d [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        set_decode(1, 1, 1, 0, 0);
        for (int i = 0; i < 13; i++) begin
            bus.MEM_WAIT = w[i];
            #1;
            checks++;
            if (strobes() !== (17'd1 << s[i])) begin
                errors++;
                $display("FAIL mem_ops_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s[i]);
            end
            checks++;
            if (bus.instr_done !== d[i]) begin
                errors++;
                $display("FAIL mem_ops_done[%0d]: got %b expected %b", i, bus.instr_done, d[i]);
            end
            if (i < 12) next_cycle();
        end
        bus.MEM_WAIT = 1'b0;
    endtask

    task automatic test_multiply();
        int  exp_s;
        int  exp_cnt;
        logic exp_done;
        set_decode(0, 0, 0, 1, 0);
        bus.MEM_WAIT = 1'b0;
        for (int c = 0; c <= 5 + 2 * MUL_ITER; c++) begin
            exp_s    = mul_phase(c);
            exp_done = (exp_s == P_MUL4);
            #1;
            checks++;
            if (strobes() !== (17'd1 << exp_s)) begin
                errors++;
                $display("FAIL mul_state[%0d]: got %h expected %h", c, strobes(), 17'd1 << exp_s);
            end
            checks++;
            if (bus.instr_done !== exp_done) begin
                errors++;
                $display("FAIL mul_done[%0d]: got %b expected %b", c, bus.instr_done, exp_done);
            end
            if (c >= 3) begin
                exp_cnt = (c < 3 + 2 * MUL_ITER) ? (c - 3) / 2 : MUL_ITER - 1;
                checks++;
                if (bus.mul_cnt !== CW'(exp_cnt)) begin
                    errors++;
                    $display("FAIL mul_cnt[%0d]: got %0d expected %0d", c, bus.mul_cnt, exp_cnt);
                end
            end
            if (c < 5 + 2 * MUL_ITER) next_cycle();
        end
        set_decode(0, 0, 0, 0, 0);
    endtask

    task automatic test_interrupts();
        int s1 [7] = '{P_IF0, P_IF1, P_FF0, P_FF1, P_FF2, P_EX0, P_IF0};
        bit e1 [7] = '{0, 0, 0, 1, 0, 0, 0};
        bit d1 [7] = '{0, 0, 0, 0, 0, 1, 0};
        int s2 [8] = '{P_IF0, P_IF1, P_EX0, P_IT0, P_IT1, P_IT1, P_IT2, P_IF0};
        bit w2 [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        bit e2 [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        bit d2 [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        int s3 [9] = '{P_IF0, P_IF1, P_EX0, P_EX1, P_EX1, P_IT0, P_IT1, P_IT2, P_IF0};
        bit w3 [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        bit o3 [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        bit d3 [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};

        // Short pulse during operand fetch must be lost.
        set_decode(1, 0, 0, 0, 0);
        bus.MEM_WAIT = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.EIT_gate = e1[i];
            #1;
            checks++;
            if (strobes() !== (17'd1 << s1[i])) begin
                errors++;
                $display("FAIL eit_pulse_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s1[i]);
            end
            checks++;
            if (bus.instr_done !== d1[i]) begin
                errors++;
                $display("FAIL eit_pulse_done[%0d]: got %b expected %b", i, bus.instr_done, d1[i]);
            end
            if (i < 6) next_cycle();
        end

        // Held request is taken at end of instruction and ignored during entry.
        set_decode(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bus.EIT_gate = e2[i];
            bus.MEM_WAIT = w2[i];
            #1;
            checks++;
            if (strobes() !== (17'd1 << s2[i])) begin
                errors++;
                $display("FAIL eit_held_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s2[i]);
            end
            checks++;
            if (bus.instr_done !== d2[i]) begin
                errors++;
                $display("FAIL eit_held_done[%0d]: got %b expected %b", i, bus.instr_done, d2[i]);
            end
            if (i < 7) next_cycle();
        end

        // Overflow request at an EX1 that waits on memory.
        set_decode(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            bus.OIT_gate = o3[i];
            bus.MEM_WAIT = w3[i];
            #1;
            checks++;
            if (strobes() !== (17'd1 << s3[i])) begin
                errors++;
                $display("FAIL oit_ex1_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s3[i]);
            end
            checks++;
            if (bus.instr_done !== d3[i]) begin
                errors++;
                $display("FAIL oit_ex1_done[%0d]: got %b expected %b", i, bus.instr_done, d3[i]);
            end
            if (i < 8) next_cycle();
        end
        bus.MEM_WAIT = 1'b0;
        bus.EIT_gate = 1'b0;
        bus.OIT_gate = 1'b0;
        set_decode(0, 0, 0, 0, 0);
    endtask

    task automatic test_svc_priority();
        int s [6] = '{P_IF0, P_IF1, P_IT0, P_IT1, P_IT2, P_IF0};
        bit d [6] = '{0, 0, 0, 0, 1, 0};
        bit mul1_seen = 1'b0;
        set_decode(1, 1, 1, 1, 1);
        bus.MEM_WAIT = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.MUL1 === 1'b1) mul1_seen = 1'b1;
            checks++;
            if (strobes() !== (17'd1 << s[i])) begin
                errors++;
                $display("FAIL svc_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s[i]);
            end
            checks++;
            if (bus.instr_done !== d[i]) begin
                errors++;
                $display("FAIL svc_done[%0d]: got %b expected %b", i, bus.instr_done, d[i]);
            end
            if (i < 5) next_cycle();
        end
        checks++;
        if (mul1_seen !== 1'b0) begin
            errors++;
            $display("FAIL svc_no_mul1: got %b expected 0", mul1_seen);
        end
        set_decode(0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        set_decode(0, 0, 0, 1, 0);
        bus.MEM_WAIT = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            #1;
            checks++;
            if (strobes() !== (17'd1 << mul_phase(c))) begin
                errors++;
                $display("FAIL areset_run_state[%0d]: got %h expected %h", c, strobes(), 17'd1 << mul_phase(c));
            end
            if (c < 18) next_cycle();
        end
        checks++;
        if (bus.mul_cnt !== 8'd7) begin
            errors++;
            $display("FAIL areset_pre_cnt: got %0d expected 7", bus.mul_cnt);
        end
        // Mid-cycle, well away from any clock edge.
        #1 CLR = 1'b0;
        #1;
        checks++;
        if (strobes() !== 17'h00001) begin
            errors++;
            $display("FAIL areset_strobes: got %h expected %h", strobes(), 17'h00001);
        end
        checks++;
        if (bus.mul_cnt !== 8'd0) begin
            errors++;
            $display("FAIL areset_mul_cnt: got %0d expected 0", bus.mul_cnt);
        end
        checks++;
        if (bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL areset_done: got %b expected 0", bus.instr_done);
        end
        #1 CLR = 1'b1;
        set_decode(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int s [9] = '{P_IF0, P_IF0, P_IF0, P_IF1, P_EX0, P_IF0, P_IF1, P_EX0, P_IF0};
        bit w [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit d [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        set_decode(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            bus.MEM_WAIT = w[i];
            #1;
            checks++;
            if (strobes() !== (17'd1 << s[i])) begin
                errors++;
                $display("FAIL b2b_state[%0d]: got %h expected %h", i, strobes(), 17'd1 << s[i]);
            end
            checks++;
            if (bus.instr_done !== d[i]) begin
                errors++;
                $display("FAIL b2b_done[%0d]: got %b expected %b", i, bus.instr_done, d[i]);
            end
            if (i < 8) next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_register_op();
        test_mem_operands();
        test_multiply();
        test_interrupts();
        test_svc_priority();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
